// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Types and defaults shared by the UART receiver and transmitter.
//             Provides the receiver FSM state enum and the default
//             oversampling ratio and data width of the serial link.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // rx_tick pulses per bit period (even, >= 8)
    localparam int UART_OVERSAMPLE = 16;
    // data bits per frame
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync2
//  Purpose  : Two-flop synchroniser for the asynchronous serial line. Both
//             flops reset to 1 so an idle-high line is never mistaken for a
//             start bit while leaving reset.
//  Ports    : clk   in  system clock
//             reset in  asynchronous active-low reset
//             d     in  asynchronous input
//             q     out synchronised output
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : 8N1 UART receiver, LSB first, idle-high line. Oversamples the
//             synchronised line with rx_tick and samples each bit mid-period.
//             Each good byte is presented with a one-cycle rx_valid pulse;
//             a low stop bit gives a one-cycle rx_frame_err pulse instead.
//  Ports    : clk          in  system clock
//             reset        in  asynchronous active-low reset
//             rx_tick      in  strobe at OVERSAMPLE x baud
//             rx           in  serial input (asynchronous)
//             rx_data      out last correctly framed byte
//             rx_valid     out 1-cycle pulse, rx_data updated
//             rx_frame_err out 1-cycle pulse, stop bit sampled low
//             rx_busy      out high from start detect until frame end
//  Revision : 1.0  initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t         state,     state_nxt;
    logic [TICK_W-1:0]      tick_cnt,  tick_nxt;
    logic [BIT_W-1:0]       bit_cnt,   bit_nxt;
    logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   armed,     armed_nxt;
    logic                   valid_nxt, ferr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            armed        <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            tick_cnt     <= tick_nxt;
            bit_cnt      <= bit_nxt;
            shift_reg    <= shift_nxt;
            armed        <= armed_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        armed_nxt = armed;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        if (rx_tick) begin
            unique case (state)
                IDLE: begin
                    // A line that stays low after a frame (break) must go
                    // high at least once before a new start edge counts.
                    if (!armed) begin
                        if (rx_s) begin
                            armed_nxt = 1'b1;
                        end
                    end else if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                        armed_nxt = 1'b0;
                    end
                end

                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_nxt = '0;
                        if (!rx_s) begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end else begin
                            // Glitch: line already high again, so re-arm.
                            state_nxt = IDLE;
                            armed_nxt = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_nxt  = '0;
                        // Right shift: first bit received ends up in the LSB.
                        shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end

                STOP: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            data_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                            // Stop bit itself proves the line is high, which
                            // allows a back-to-back start on the next tick.
                            armed_nxt = 1'b1;
                        end else begin
                            ferr_nxt  = 1'b1;
                            armed_nxt = 1'b0;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver. Directed frames are
//             driven on rx; expected pulses go into a scoreboard queue that
//             an independent monitor drains whenever the DUT pulses.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [1:0] tdiv = 2'd0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign rx_tick = (tdiv == 2'd3);

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_tick      (rx_tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (reset && (rx_valid || rx_frame_err)) begin
            if (rx_valid && rx_frame_err) begin
                tests++;
                fails++;
                $display("FAIL pulse_overlap: got valid=1 ferr=1 expected at most one");
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got ferr=%0b data=%0h expected none",
                         rx_frame_err, rx_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("scoreboard", {23'd0, rx_frame_err, rx_data}, {23'd0, e.ferr, e.data});
            end
        end
    end

    task automatic expect_byte(input logic [7:0] d);
        sb.push_back('{ferr: 1'b0, data: d});
        last_good = d;
    endtask

    task automatic expect_ferr();
        sb.push_back('{ferr: 1'b1, data: last_good});
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
    endtask

    // Drives the first nbits of {stop, data, start}, LSB (start) first.
    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               input int bit_clk, input int nbits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) hold(f[i], bit_clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int bit_clk);
        if (stop) expect_byte(d);
        else      expect_ferr();
        drive_frame(d, stop, bit_clk, 10);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  {24'd0, rx_data}, 32'h0);
        check("reset_valid", {31'd0, rx_valid}, 32'h0);
        check("reset_ferr",  {31'd0, rx_frame_err}, 32'h0);
        check("reset_busy",  {31'd0, rx_busy}, 32'h0);
        @(negedge clk) reset = 1'b1;
        hold(1'b1, 2 * BIT_CLK);

        // 1: single frame
        send(8'hA5, 1'b1, BIT_CLK);
        hold(1'b1, 2 * BIT_CLK);

        // 2: back-to-back frames
        send(8'h00, 1'b1, BIT_CLK);
        send(8'hFF, 1'b1, BIT_CLK);
        send(8'h3C, 1'b1, BIT_CLK);
        hold(1'b1, 2 * BIT_CLK);

        // 3: framing error, then line held low (break)
        send(8'h5A, 1'b0, BIT_CLK);
        hold(1'b0, 2 * BIT_CLK);
        check("break_busy_a", {31'd0, rx_busy}, 32'h0);
        hold(1'b0, 8 * BIT_CLK);
        check("break_busy_b", {31'd0, rx_busy}, 32'h0);
        hold(1'b1, 2 * BIT_CLK);

        // 4: short low glitch of 3 ticks
        begin
            bit rose, fell;
            rose = 1'b0;
            fell = 1'b0;
            rx = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (i == 12) rx = 1'b1;
                if (rx_busy) begin
                    rose = 1'b1;
                    break;
                end
            end
            rx = 1'b1;
            check("glitch_busy_rise", {31'd0, rose}, 32'h1);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!rx_busy) begin
                    fell = 1'b1;
                    break;
                end
            end
            check("glitch_busy_fall", {31'd0, fell}, 32'h1);
            hold(1'b1, 2 * BIT_CLK);
        end

        // 5: reset during data bit 4 of 0x81
        drive_frame(8'h81, 1'b1, BIT_CLK, 5);
        hold(1'b0, 20);
        #1;
        check("mid_busy", {31'd0, rx_busy}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("abort_data",  {24'd0, rx_data}, 32'h0);
        check("abort_busy",  {31'd0, rx_busy}, 32'h0);
        check("abort_valid", {31'd0, rx_valid}, 32'h0);
        check("abort_ferr",  {31'd0, rx_frame_err}, 32'h0);
        last_good = 8'h00;
        hold(1'b1, 5);
        @(negedge clk) reset = 1'b1;
        hold(1'b1, 2 * BIT_CLK);
        send(8'h81, 1'b1, BIT_CLK);
        hold(1'b1, 2 * BIT_CLK);

        // 6: +/-3% bit period skew
        send(8'hC3, 1'b1, 62);
        hold(1'b1, 2 * BIT_CLK);
        send(8'hC3, 1'b1, 66);
        hold(1'b1, 2 * BIT_CLK);

        // Drain: every expected pulse must have been seen
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'h0);
        check("final_data", {24'd0, rx_data}, 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_receiver
`default_nettype wire
